// File: rtl/mac_array_tile_if.sv
// Host-side bundle for mac_array_tile: operand writes, pass control and the C result stream.
// master = host/consumer, slave = tile.
interface mac_array_tile_if #(
    parameter int ROWS = 2,
    parameter int COLS = 4,
    parameter int DW   = 32,
    parameter int KMAX = 8,
    parameter int ACCW = 2*DW + $clog2(KMAX)
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int KW = $clog2(KMAX);
    localparam int LW = $clog2(KMAX+1);

    logic            a_wr_en;
    logic [RW-1:0]   a_wr_row;
    logic [KW-1:0]   a_wr_k;
    logic [DW-1:0]   a_wr_data;
    logic            b_wr_en;
    logic [KW-1:0]   b_wr_k;
    logic [CW-1:0]   b_wr_col;
    logic [DW-1:0]   b_wr_data;
    logic            start;
    logic [LW-1:0]   k_len;
    logic            acc_mode;
    logic            busy;
    logic            done;
    logic            c_valid;
    logic            c_ready;
    logic [ACCW-1:0] c_data;
    logic [RW-1:0]   c_row;
    logic [CW-1:0]   c_col;
    logic            c_last;

    modport master (
        output a_wr_en, a_wr_row, a_wr_k, a_wr_data,
        output b_wr_en, b_wr_k, b_wr_col, b_wr_data,
        output start, k_len, acc_mode, c_ready,
        input  busy, done, c_valid, c_data, c_row, c_col, c_last
    );

    modport slave (
        input  a_wr_en, a_wr_row, a_wr_k, a_wr_data,
        input  b_wr_en, b_wr_k, b_wr_col, b_wr_data,
        input  start, k_len, acc_mode, c_ready,
        output busy, done, c_valid, c_data, c_row, c_col, c_last
    );
endinterface

// File: rtl/mac_array_tile.sv
// ROWS x COLS MAC tile, C += A*B over k_len; first C word k_len+1 cycles after start (1 when k_len==0).
// C drains row-major on valid/ready; the drain index only moves on a handshake, so c_ready=0 freezes it.
module mac_array_tile #(
    parameter int ROWS   = 2,
    parameter int COLS   = 4,
    parameter int DW     = 32,
    parameter int KMAX   = 8,
    parameter int SIGNED = 0,
    parameter int ACCW   = 2*DW + $clog2(KMAX)
) (
    input  logic           clk,
    input  logic           rst,
    mac_array_tile_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int KW = $clog2(KMAX);
    localparam int LW = $clog2(KMAX+1);

    typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} state_t;

    state_t          state;
    state_t          state_nxt;

    logic [DW-1:0]   a_mem [ROWS][KMAX];
    logic [DW-1:0]   b_mem [KMAX][COLS];
    logic [ACCW-1:0] acc   [ROWS][COLS];
    logic [ACCW-1:0] prod  [ROWS][COLS];

    logic [LW-1:0]   k_cnt;
    logic [LW-1:0]   k_last;
    logic [KW-1:0]   k_idx;
    logic [RW-1:0]   dr_row;
    logic [CW-1:0]   dr_col;
    logic            done_q;

    logic            idle;
    logic            hs;
    logic            at_last;
    logic            drain_end;
    logic [LW-1:0]   k_len_clamp;

    // Sign- or zero-extend both operands to 2*DW so one multiplier covers both modes;
    // the 2*DW product is exact either way, then widened to the accumulator.
    function automatic logic [ACCW-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic           sa;
        logic           sb;
        logic [2*DW-1:0] p;
        sa = (SIGNED != 0) && a[DW-1];
        sb = (SIGNED != 0) && b[DW-1];
        p  = {{DW{sa}}, a} * {{DW{sb}}, b};
        return {{(ACCW-2*DW){(SIGNED != 0) && p[2*DW-1]}}, p};
    endfunction

    assign idle        = (state == IDLE);
    assign hs          = (state == DRAIN) && bus.c_ready;
    assign at_last     = (dr_row == RW'(ROWS-1)) && (dr_col == CW'(COLS-1));
    assign drain_end   = hs && at_last;
    assign k_len_clamp = (bus.k_len > LW'(KMAX)) ? LW'(KMAX) : bus.k_len;
    assign k_idx       = k_cnt[KW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (k_len_clamp == '0) ? DRAIN : COMPUTE;
                end
            end
            COMPUTE: begin
                if (k_cnt == k_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state != IDLE);
        bus.done    = done_q;
        bus.c_valid = (state == DRAIN);
        bus.c_data  = '0;
        bus.c_row   = '0;
        bus.c_col   = '0;
        bus.c_last  = 1'b0;
        if (state == DRAIN) begin
            bus.c_data = acc[dr_row][dr_col];
            bus.c_row  = dr_row;
            bus.c_col  = dr_col;
            bus.c_last = at_last;
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                prod[r][c] = mul_ext(a_mem[r][k_idx], b_mem[k_idx][c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int k = 0; k < KMAX; k++) begin
                    a_mem[r][k] <= '0;
                end
                for (int c = 0; c < COLS; c++) begin
                    acc[r][c] <= '0;
                end
            end
            for (int k = 0; k < KMAX; k++) begin
                for (int c = 0; c < COLS; c++) begin
                    b_mem[k][c] <= '0;
                end
            end
            k_cnt  <= '0;
            k_last <= '0;
            dr_row <= '0;
            dr_col <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= drain_end;

            // Operand writes land on the same edge as start, so that pass already sees them.
            if (idle) begin
                if (bus.a_wr_en && (int'(bus.a_wr_row) < ROWS) && (int'(bus.a_wr_k) < KMAX)) begin
                    a_mem[bus.a_wr_row][bus.a_wr_k] <= bus.a_wr_data;
                end
                if (bus.b_wr_en && (int'(bus.b_wr_k) < KMAX) && (int'(bus.b_wr_col) < COLS)) begin
                    b_mem[bus.b_wr_k][bus.b_wr_col] <= bus.b_wr_data;
                end
                if (bus.start) begin
                    k_cnt  <= '0;
                    k_last <= k_len_clamp - LW'(1);
                    dr_row <= '0;
                    dr_col <= '0;
                    if (!bus.acc_mode) begin
                        for (int r = 0; r < ROWS; r++) begin
                            for (int c = 0; c < COLS; c++) begin
                                acc[r][c] <= '0;
                            end
                        end
                    end
                end
            end

            if (state == COMPUTE) begin
                k_cnt <= k_cnt + LW'(1);
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        acc[r][c] <= acc[r][c] + prod[r][c];
                    end
                end
            end

            if (hs) begin
                if (dr_col == CW'(COLS-1)) begin
                    dr_col <= '0;
                    dr_row <= dr_row + RW'(1);
                end else begin
                    dr_col <= dr_col + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_array_tile.sv
// Drives an unsigned and a signed tile with identical stimulus; a pass-level model
// predicts every cycle of busy/done/C stream, and literal results pin the model.
module tb_mac_array_tile;
    localparam int ROWS = 2;
    localparam int COLS = 4;
    localparam int DW   = 32;
    localparam int KMAX = 8;
    localparam int ACCW = 2*DW + $clog2(KMAX);
    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);
    localparam int KW   = $clog2(KMAX);
    localparam int LW   = $clog2(KMAX+1);
    localparam int NEL  = ROWS*COLS;
    localparam int NA   = ROWS*KMAX;
    localparam int NB   = KMAX*COLS;
    localparam int NL   = (NA > NB) ? NA : NB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            a_wr_en;
    logic [RW-1:0]   a_wr_row;
    logic [KW-1:0]   a_wr_k;
    logic [DW-1:0]   a_wr_data;
    logic            b_wr_en;
    logic [KW-1:0]   b_wr_k;
    logic [CW-1:0]   b_wr_col;
    logic [DW-1:0]   b_wr_data;
    logic            start;
    logic [LW-1:0]   k_len;
    logic            acc_mode;
    logic            c_ready;

    mac_array_tile_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .KMAX(KMAX), .ACCW(ACCW)) bus_u ();
    mac_array_tile_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .KMAX(KMAX), .ACCW(ACCW)) bus_s ();

    assign bus_u.a_wr_en = a_wr_en;     assign bus_s.a_wr_en = a_wr_en;
    assign bus_u.a_wr_row = a_wr_row;   assign bus_s.a_wr_row = a_wr_row;
    assign bus_u.a_wr_k = a_wr_k;       assign bus_s.a_wr_k = a_wr_k;
    assign bus_u.a_wr_data = a_wr_data; assign bus_s.a_wr_data = a_wr_data;
    assign bus_u.b_wr_en = b_wr_en;     assign bus_s.b_wr_en = b_wr_en;
    assign bus_u.b_wr_k = b_wr_k;       assign bus_s.b_wr_k = b_wr_k;
    assign bus_u.b_wr_col = b_wr_col;   assign bus_s.b_wr_col = b_wr_col;
    assign bus_u.b_wr_data = b_wr_data; assign bus_s.b_wr_data = b_wr_data;
    assign bus_u.start = start;         assign bus_s.start = start;
    assign bus_u.k_len = k_len;         assign bus_s.k_len = k_len;
    assign bus_u.acc_mode = acc_mode;   assign bus_s.acc_mode = acc_mode;
    assign bus_u.c_ready = c_ready;     assign bus_s.c_ready = c_ready;

    mac_array_tile #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .KMAX(KMAX), .SIGNED(0), .ACCW(ACCW))
        u_dut_u (.clk(clk), .rst(rst), .bus(bus_u.slave));
    mac_array_tile #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .KMAX(KMAX), .SIGNED(1), .ACCW(ACCW))
        u_dut_s (.clk(clk), .rst(rst), .bus(bus_s.slave));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [ACCW-1:0] act, input logic [ACCW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        check(nm, ACCW'(act), ACCW'(exp));
    endtask

    // Reference model: whole-matrix result computed at start, then replayed as an expected stream.
    typedef struct {
        logic [ACCW-1:0] du;
        logic [ACCW-1:0] ds;
        int              row;
        int              col;
    } elem_t;

    logic [DW-1:0]          m_a     [ROWS][KMAX];
    logic [DW-1:0]          m_b     [KMAX][COLS];
    logic [ACCW-1:0]        m_acc_u [ROWS][COLS];
    logic signed [ACCW-1:0] m_acc_s [ROWS][COLS];
    elem_t                  exp_q[$];
    elem_t                  e;
    int                     m_phase = 0;   // 0 idle, 1 computing, 2 draining
    int                     m_cnt   = 0;
    int                     m_len   = 0;
    logic                   m_done  = 1'b0;
    bit                     m_live  = 1'b0;
    logic [ACCW-1:0]        cap_u[$];
    logic [ACCW-1:0]        cap_s[$];

    always @(negedge clk) begin
        if (m_live) begin
            check1("busy_u", bus_u.busy, m_phase != 0);
            check1("busy_s", bus_s.busy, m_phase != 0);
            check1("done_u", bus_u.done, m_done);
            check1("done_s", bus_s.done, m_done);
            check1("valid_u", bus_u.c_valid, m_phase == 2);
            check1("valid_s", bus_s.c_valid, m_phase == 2);
            if (m_phase == 2 && exp_q.size() > 0) begin
                check("data_u", bus_u.c_data, exp_q[0].du);
                check("data_s", bus_s.c_data, exp_q[0].ds);
                check("row_u", ACCW'(bus_u.c_row), ACCW'(exp_q[0].row));
                check("col_u", ACCW'(bus_u.c_col), ACCW'(exp_q[0].col));
                check("row_s", ACCW'(bus_s.c_row), ACCW'(exp_q[0].row));
                check("col_s", ACCW'(bus_s.c_col), ACCW'(exp_q[0].col));
                check1("last_u", bus_u.c_last, exp_q.size() == 1);
                check1("last_s", bus_s.c_last, exp_q.size() == 1);
                if (c_ready) begin
                    cap_u.push_back(bus_u.c_data);
                    cap_s.push_back(bus_s.c_data);
                end
            end
        end
        m_done = 1'b0;
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int k = 0; k < KMAX; k++) m_a[r][k] = '0;
                for (int c = 0; c < COLS; c++) begin
                    m_acc_u[r][c] = '0;
                    m_acc_s[r][c] = '0;
                end
            end
            for (int k = 0; k < KMAX; k++)
                for (int c = 0; c < COLS; c++) m_b[k][c] = '0;
            exp_q.delete();
            m_phase = 0;
            m_live  = 1'b1;
        end else if (m_live) begin
            case (m_phase)
                0: begin
                    if (a_wr_en && int'(a_wr_row) < ROWS && int'(a_wr_k) < KMAX) m_a[a_wr_row][a_wr_k] = a_wr_data;
                    if (b_wr_en && int'(b_wr_k) < KMAX && int'(b_wr_col) < COLS) m_b[b_wr_k][b_wr_col] = b_wr_data;
                    if (start) begin
                        m_len = (int'(k_len) > KMAX) ? KMAX : int'(k_len);
                        for (int r = 0; r < ROWS; r++) begin
                            for (int c = 0; c < COLS; c++) begin
                                if (!acc_mode) begin
                                    m_acc_u[r][c] = '0;
                                    m_acc_s[r][c] = '0;
                                end
                                for (int k = 0; k < m_len; k++) begin
                                    m_acc_u[r][c] = m_acc_u[r][c] + m_a[r][k] * m_b[k][c];
                                    m_acc_s[r][c] = m_acc_s[r][c] + $signed(m_a[r][k]) * $signed(m_b[k][c]);
                                end
                                e.du = m_acc_u[r][c];
                                e.ds = m_acc_s[r][c];
                                e.row = r;
                                e.col = c;
                                exp_q.push_back(e);
                            end
                        end
                        m_cnt   = m_len;
                        m_phase = (m_len == 0) ? 2 : 1;
                    end
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) m_phase = 2;
                end
                default: begin
                    if (c_ready) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) begin
                            m_phase = 0;
                            m_done  = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] a_val(input int mode, input int r, input int k);
        case (mode)
            0:       return (k == 0) ? DW'(r + 1) : '0;
            1:       return '1;
            2:       return DW'(-3);
            default: return DW'($urandom);
        endcase
    endfunction

    function automatic logic [DW-1:0] b_val(input int mode, input int k, input int c);
        case (mode)
            0:       return (k == 0) ? DW'(c + 1) : '0;
            1:       return '1;
            2:       return DW'(5);
            default: return ($urandom_range(3) == 0) ? '1 : DW'($urandom);
        endcase
    endfunction

    task automatic load(input int mode);
        for (int i = 0; i < NL; i++) begin
            a_wr_en   = (i < NA);
            a_wr_row  = RW'(i / KMAX);
            a_wr_k    = KW'(i % KMAX);
            a_wr_data = a_val(mode, i / KMAX, i % KMAX);
            b_wr_en   = (i < NB);
            b_wr_k    = KW'(i / COLS);
            b_wr_col  = CW'(i % COLS);
            b_wr_data = b_val(mode, i / COLS, i % COLS);
            tick();
        end
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
    endtask

    task automatic wait_done(input int rdy_pct);
        bit got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            c_ready = ($urandom_range(99) < rdy_pct);
            tick();
            got = bus_u.done;
        end
        c_ready = 1'b1;
        check1("pass_done", got, 1'b1);
    endtask

    task automatic run_pass(input int kl, input bit am, input int rdy_pct, input bit wr_with_start);
        cap_u.delete();
        cap_s.delete();
        start    = 1'b1;
        k_len    = LW'(kl);
        acc_mode = am;
        if (wr_with_start) begin
            a_wr_en   = 1'b1;
            a_wr_row  = RW'($urandom_range(ROWS-1));
            a_wr_k    = KW'($urandom_range(KMAX-1));
            a_wr_data = $urandom;
            b_wr_en   = 1'b1;
            b_wr_k    = KW'($urandom_range(KMAX-1));
            b_wr_col  = CW'($urandom_range(COLS-1));
            b_wr_data = $urandom;
        end
        tick();
        start   = 1'b0;
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
        wait_done(rdy_pct);
    endtask

    task automatic pin_stream1(input string nm);
        check({nm, "_n"}, ACCW'(cap_u.size()), ACCW'(NEL));
        for (int i = 0; i < cap_u.size() && i < NEL; i++) begin
            check({nm, "_u"}, cap_u[i], ACCW'(((i / COLS) + 1) * ((i % COLS) + 1)));
            check({nm, "_s"}, cap_s[i], ACCW'(((i / COLS) + 1) * ((i % COLS) + 1)));
        end
    endtask

    logic [ACCW-1:0]        ref_u[$];
    logic [ACCW-1:0]        ref_s[$];
    logic signed [ACCW-1:0] lit;
    bit                     got3;

    initial begin
        a_wr_en = 0; a_wr_row = '0; a_wr_k = '0; a_wr_data = '0;
        b_wr_en = 0; b_wr_k = '0; b_wr_col = '0; b_wr_data = '0;
        start = 0; k_len = '0; acc_mode = 0; c_ready = 1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_data", bus_u.c_data, '0);
        check("rst_row", ACCW'(bus_u.c_row), '0);
        check("rst_col", ACCW'(bus_u.c_col), '0);
        check1("rst_last", bus_u.c_last, 1'b0);
        check1("rst_valid", bus_s.c_valid, 1'b0);

        // 1..8 stream with k_len=1
        load(0);
        run_pass(1, 1'b0, 100, 1'b0);
        pin_stream1("pat1");

        // same pass with a 5-cycle stall after three handshakes
        cap_u.delete();
        cap_s.delete();
        start = 1'b1; k_len = LW'(1); acc_mode = 1'b0;
        tick();
        start = 1'b0;
        got3 = 1'b0;
        for (int i = 0; i < 50 && !got3; i++) begin
            if (cap_u.size() >= 3) got3 = 1'b1;
            else tick();
        end
        c_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_data", bus_u.c_data, ACCW'(4));
            check("stall_col", ACCW'(bus_u.c_col), ACCW'(3));
            check1("stall_valid", bus_u.c_valid, 1'b1);
        end
        wait_done(100);
        pin_stream1("stall");

        // all-ones operands, full depth: exact 8*(2^32-1)^2 unsigned, 8 signed
        load(1);
        run_pass(8, 1'b0, 70, 1'b0);
        check("allf_n", ACCW'(cap_u.size()), ACCW'(NEL));
        for (int i = 0; i < cap_u.size(); i++) begin
            check("allf_u", cap_u[i], 67'h7_FFFF_FFF0_0000_0008);
            check("allf_s", cap_s[i], ACCW'(8));
        end

        // signed -3*5 over k_len=2, then accumulate once more
        load(2);
        run_pass(2, 1'b0, 100, 1'b0);
        lit = -30;
        for (int i = 0; i < cap_s.size(); i++) check("neg30_s", cap_s[i], lit);
        run_pass(2, 1'b1, 80, 1'b0);
        lit = -60;
        check("neg60_n", ACCW'(cap_s.size()), ACCW'(NEL));
        for (int i = 0; i < cap_s.size(); i++) check("neg60_s", cap_s[i], lit);

        // writes during COMPUTE and start during DRAIN must not disturb the result
        load(3);
        run_pass(5, 1'b0, 100, 1'b0);
        ref_u = cap_u;
        ref_s = cap_s;
        cap_u.delete();
        cap_s.delete();
        start = 1'b1; k_len = LW'(5); acc_mode = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_wr_en = 1'b1; a_wr_row = RW'($urandom_range(ROWS-1)); a_wr_k = KW'($urandom_range(KMAX-1));
            a_wr_data = $urandom;
            b_wr_en = 1'b1; b_wr_k = KW'($urandom_range(KMAX-1)); b_wr_col = CW'($urandom_range(COLS-1));
            b_wr_data = $urandom;
            tick();
        end
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
        c_ready = 1'b0;
        start = 1'b1; k_len = LW'(3); acc_mode = 1'b1;
        tick();
        start = 1'b0;
        wait_done(60);
        check("dist_n", ACCW'(cap_u.size()), ACCW'(NEL));
        for (int i = 0; i < cap_u.size() && i < ref_u.size(); i++) begin
            check("dist_u", cap_u[i], ref_u[i]);
            check("dist_s", cap_s[i], ref_s[i]);
        end

        // randomized passes: k_len up to 15 (clamped), mixed acc_mode, random backpressure
        for (int p = 0; p < 16; p++) begin
            if (p % 4 == 0) load(3);
            run_pass($urandom_range(15), 1'($urandom_range(1)), 60, 1'($urandom_range(1)));
        end

        // reset in the third COMPUTE cycle, then an empty pass drains zeros
        load(3);
        start = 1'b1; k_len = LW'(8); acc_mode = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("rstmid_busy_u", bus_u.busy, 1'b0);
        check1("rstmid_valid_u", bus_u.c_valid, 1'b0);
        check1("rstmid_busy_s", bus_s.busy, 1'b0);
        check1("rstmid_valid_s", bus_s.c_valid, 1'b0);
        run_pass(0, 1'b1, 100, 1'b0);
        check("zero_n", ACCW'(cap_u.size()), ACCW'(NEL));
        for (int i = 0; i < cap_u.size(); i++) begin
            check("zero_u", cap_u[i], '0);
            check("zero_s", cap_s[i], '0);
        end

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
